bcd_tick_counter: RTL and testbench
===================================

// Module: bcd_tick_counter
// PURPOSE
//  Two-digit BCD up/down counter stepped by the divided slow clock (Clk5Hz) from the 50 MHz clock divider.
//  Clk5Hz is treated as data: it is synchronised and edge-detected in the Clk50MHz domain, so there is one clock domain.
//  Drives stopwatch/timer displays and LED sequencing on the board, one count per slow-clock period.
// PARAMETERS
//  MAX_TENS  5  tens digit of the terminal count (0..9)
//  MAX_ONES  9  ones digit of the terminal count (0..9); terminal count = MAX_TENS*10+MAX_ONES (default 59)
// PORTS
//  Clk50MHz  in   1  system clock, 50 MHz, rising edge
//  Rst_n     in   1  reset, synchronous, active-low
//  Clk5Hz    in   1  slow clock from divider, asynchronous-to-logic, sampled as data
//  En        in   1  1 = count on slow-clock rising edges; 0 = hold
//  Up        in   1  1 = increment, 0 = decrement
//  Clr       in   1  synchronous clear to 00 (level)
//  Load      in   1  load LoadVal (level, applied every cycle high)
//  LoadVal   in   8  BCD {tens,ones}
//  Tens      out  4  tens digit, BCD
//  Ones      out  4  ones digit, BCD
//  Tick      out  1  one-cycle pulse, the cycle after a step is applied
//  Wrap      out  1  one-cycle pulse, coincident with Tick, when the step wrapped
//  LoadErr   out  1  one-cycle pulse, the cycle after a rejected Load
// BEHAVIOUR
//  Reset (Rst_n=0 at a Clk50MHz edge): Tens=Ones=0, Tick=Wrap=LoadErr=0, sync flops=0, Armed=0.
//  Sync: s0<=Clk5Hz; s1<=s0; s2<=s1. Armed<=1 once s1==0 is sampled after reset; Armed stays 1 until reset.
//  Edge = Armed & s1 & ~s2. A level already high at reset release produces no step until it falls and rises again.
//  Latency: Clk5Hz high before edge n -> count updates at edge n+2 -> Tick high during cycle after n+2.
//  Priority per cycle: Rst_n > Clr > Load > step (Edge & En). A dropped Edge is lost, not queued.
//  Clr: count<=00; Tick=Wrap=0.
//  Load: valid when both digits<=9 and value<=terminal -> count<=LoadVal; otherwise count holds and LoadErr=1 next cycle.
//  Step up: Ones==9 -> Ones=0, Tens+1. At terminal {MAX_TENS,MAX_ONES} -> 00 and Wrap=1.
//  Step down: Ones==0 -> Ones=9, Tens-1. At 00 -> {MAX_TENS,MAX_ONES} and Wrap=1.
//  Tick=1 for exactly one cycle per applied step. Never asserted for Clr or Load.
//  Count is always valid BCD and <= terminal. Up or En changes take effect at the next Edge.
//  Reset mid-count: immediate return to reset state. The pending sync state is discarded.
// CONFIGURATION
//  SEVEN_SEG_EN defined: adds outputs SegTens[6:0] and SegOnes[6:0], active-low, bit order {g,f,e,d,c,b,a}.
//   Registered, one cycle after Tens/Ones change. Reset value 7'b1000000 ("0"). Digit 9 = 7'b0010000.
//  SEVEN_SEG_EN undefined: Seg ports and decode logic absent. All other behaviour identical.
// STRUCTURE
//  Package bcd_pkg: BCD digit typedef (4-bit), SEG_* active-low 7-seg constants 0..9, SEG_BLANK.
//  Sub-module slow_edge_sync: s0/s1/s2 + Armed -> Edge.
//   Reusable by every consumer of the divider output.
//  Counter/wrap/load checks and optional decode live in bcd_tick_counter.
// TESTING (bench drives Clk5Hz directly with short pulses, >=4 Clk50MHz cycles high and low)
//  1 Clk5Hz=1 during reset, release -> no Tick while high; after low->high -> one Tick, count 01.
//  2 En=1, Up=1, 12 rising edges from 00 -> Tens=1, Ones=2.
//    Exactly 12 Tick pulses, each 3 edges after its Clk5Hz rise.
//  3 Load 8'h59, Up=1, one edge -> 00 with Tick=Wrap=1 same cycle.
//    Up=0 from 00, one edge -> 59, Wrap=1.
//  4 Clr high in the cycle Edge is true -> count 00, Tick=0.
//    En=0 with 3 edges -> count unchanged, no Tick.
//  5 Load 8'h6A and 8'h60 -> count unchanged, LoadErr pulses.
//    Load 8'h37 -> 37, LoadErr=0.
//  6 SEVEN_SEG_EN: count 09 -> SegTens=7'b1000000, SegOnes=7'b0010000, one cycle after Ones=9.
//    Rst_n low mid-count -> all outputs at reset values at next edge.

Source files
------------

// File: rtl/bcd_pkg.sv
// Package for the BCD tick counter family.
// Holds the BCD digit type, the active-low seven-segment patterns for
// digits 0..9 plus blank (bit order {g,f,e,d,c,b,a}), and a decode helper.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input bcd_digit_t d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/slow_edge_sync.sv
// Synchroniser and rising-edge detector for a slow divided clock that is
// handled as data in the fast clock domain.
// Ports:
//   clk       in  fast system clock, rising edge
//   rst_n     in  synchronous active-low reset
//   slow_clk  in  slow clock, asynchronous to clk
//   rise_edge out one-cycle pulse per qualified rising edge of slow_clk
//   armed     out detector has seen a genuine low level since reset
module slow_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic slow_clk,
  output logic rise_edge,
  output logic armed
);

  logic s0, s1, s2;
  // fill0/fill1 mark that s0/s1 hold real samples rather than reset zeros,
  // so a level already high at reset release cannot arm the detector.
  logic fill0, fill1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0    <= 1'b0;
      s1    <= 1'b0;
      s2    <= 1'b0;
      fill0 <= 1'b0;
      fill1 <= 1'b0;
      armed <= 1'b0;
    end else begin
      s0    <= slow_clk;
      s1    <= s0;
      s2    <= s1;
      fill0 <= 1'b1;
      fill1 <= fill0;
      if (fill1 && !s1) armed <= 1'b1;
    end
  end

  assign rise_edge = armed & s1 & ~s2;

endmodule

// File: rtl/bcd_tick_counter.sv
// Two-digit BCD up/down counter stepped by rising edges of a slow clock
// that is synchronised into the Clk50MHz domain.
// Optional feature macro: SEVEN_SEG_EN adds registered active-low
// seven-segment outputs SegTens/SegOnes ({g,f,e,d,c,b,a}).
// Ports:
//   Clk50MHz in  system clock
//   Rst_n    in  synchronous active-low reset
//   Clk5Hz   in  slow clock, sampled as data
//   En       in  1 = count on slow-clock rising edges
//   Up       in  1 = increment, 0 = decrement
//   Clr      in  synchronous clear to 00 (highest priority after reset)
//   Load     in  load LoadVal when it is valid BCD and <= terminal count
//   LoadVal  in  {tens,ones} BCD
//   Tens     out tens digit
//   Ones     out ones digit
//   Tick     out one-cycle pulse coincident with an applied step
//   Wrap     out one-cycle pulse with Tick when the step wrapped
//   LoadErr  out one-cycle pulse the cycle after a rejected Load
//   SegTens  out (SEVEN_SEG_EN) tens digit segments
//   SegOnes  out (SEVEN_SEG_EN) ones digit segments
module bcd_tick_counter
  import bcd_pkg::*;
#(
  parameter int unsigned MAX_TENS = 5,
  parameter int unsigned MAX_ONES = 9
) (
  input  logic       Clk50MHz,
  input  logic       Rst_n,
  input  logic       Clk5Hz,
  input  logic       En,
  input  logic       Up,
  input  logic       Clr,
  input  logic       Load,
  input  logic [7:0] LoadVal,
  output logic [3:0] Tens,
  output logic [3:0] Ones,
  output logic       Tick,
  output logic       Wrap,
  output logic       LoadErr
`ifdef SEVEN_SEG_EN
  ,
  output logic [6:0] SegTens,
  output logic [6:0] SegOnes
`endif
);

  localparam bcd_digit_t TERM_T = 4'(MAX_TENS);
  localparam bcd_digit_t TERM_O = 4'(MAX_ONES);
  localparam logic [7:0] TERM   = {TERM_T, TERM_O};

  logic       rise_edge;
  logic       sync_armed;
  logic       step;
  logic       load_ok;
  logic       at_term;
  logic       at_zero;
  bcd_digit_t next_tens;
  bcd_digit_t next_ones;
  logic       next_wrap;

  slow_edge_sync u_sync (
    .clk       (Clk50MHz),
    .rst_n     (Rst_n),
    .slow_clk  (Clk5Hz),
    .rise_edge (rise_edge),
    .armed     (sync_armed)
  );

  // Armed is folded into rise_edge already; keep it visible as a named net.
  assign step = rise_edge & sync_armed & En;

  // With both digits valid BCD, the packed byte orders the same as the
  // decimal value, so a plain byte compare against TERM is enough.
  assign load_ok = (LoadVal[7:4] <= 4'd9) && (LoadVal[3:0] <= 4'd9) &&
                   (LoadVal <= TERM);

  assign at_term = (Tens == TERM_T) && (Ones == TERM_O);
  assign at_zero = (Tens == 4'd0) && (Ones == 4'd0);

  always_comb begin
    next_tens = Tens;
    next_ones = Ones;
    next_wrap = 1'b0;
    if (Up) begin
      if (at_term) begin
        next_tens = 4'd0;
        next_ones = 4'd0;
        next_wrap = 1'b1;
      end else if (Ones == 4'd9) begin
        next_ones = 4'd0;
        next_tens = Tens + 4'd1;
      end else begin
        next_ones = Ones + 4'd1;
      end
    end else begin
      if (at_zero) begin
        next_tens = TERM_T;
        next_ones = TERM_O;
        next_wrap = 1'b1;
      end else if (Ones == 4'd0) begin
        next_ones = 4'd9;
        next_tens = Tens - 4'd1;
      end else begin
        next_ones = Ones - 4'd1;
      end
    end
  end

  // Clr > Load > step; an edge arriving in a Clr/Load cycle is dropped.
  always_ff @(posedge Clk50MHz) begin
    if (!Rst_n) begin
      Tens    <= 4'd0;
      Ones    <= 4'd0;
      Tick    <= 1'b0;
      Wrap    <= 1'b0;
      LoadErr <= 1'b0;
    end else begin
      Tick    <= 1'b0;
      Wrap    <= 1'b0;
      LoadErr <= 1'b0;
      if (Clr) begin
        Tens <= 4'd0;
        Ones <= 4'd0;
      end else if (Load) begin
        if (load_ok) begin
          Tens <= LoadVal[7:4];
          Ones <= LoadVal[3:0];
        end else begin
          LoadErr <= 1'b1;
        end
      end else if (step) begin
        Tens <= next_tens;
        Ones <= next_ones;
        Tick <= 1'b1;
        Wrap <= next_wrap;
      end
    end
  end

`ifdef SEVEN_SEG_EN
  // Registered decode: segments follow the digits one cycle later.
  always_ff @(posedge Clk50MHz) begin
    if (!Rst_n) begin
      SegTens <= SEG_0;
      SegOnes <= SEG_0;
    end else begin
      SegTens <= seg_decode(Tens);
      SegOnes <= seg_decode(Ones);
    end
  end
`endif

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Self-checking bench for bcd_tick_counter (default terminal count 59).
// Expected step results are queued when a slow-clock rise is driven and
// compared when Tick appears. Define SEVEN_SEG_EN to also cover the
// seven-segment outputs.
module tb_bcd_tick_counter;

  localparam int TERM = 59;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_SEVEN = 7'b1111000;
  localparam logic [6:0] SEG_NINE  = 7'b0010000;

  logic       Clk50MHz = 1'b0;
  logic       Rst_n    = 1'b0;
  logic       Clk5Hz   = 1'b0;
  logic       En       = 1'b0;
  logic       Up       = 1'b1;
  logic       Clr      = 1'b0;
  logic       Load     = 1'b0;
  logic [7:0] LoadVal  = 8'h00;
  logic [3:0] Tens;
  logic [3:0] Ones;
  logic       Tick;
  logic       Wrap;
  logic       LoadErr;
`ifdef SEVEN_SEG_EN
  logic [6:0] SegTens;
  logic [6:0] SegOnes;
`endif

  int n_checks  = 0;
  int n_fail    = 0;
  int model_val = 0;
  int tick_seen = 0;
  int base;

  // {wrap, tens, ones}
  logic [8:0] exp_q[$];

  bcd_tick_counter dut (
    .Clk50MHz (Clk50MHz),
    .Rst_n    (Rst_n),
    .Clk5Hz   (Clk5Hz),
    .En       (En),
    .Up       (Up),
    .Clr      (Clr),
    .Load     (Load),
    .LoadVal  (LoadVal),
    .Tens     (Tens),
    .Ones     (Ones),
    .Tick     (Tick),
    .Wrap     (Wrap),
    .LoadErr  (LoadErr)
`ifdef SEVEN_SEG_EN
    ,
    .SegTens  (SegTens),
    .SegOnes  (SegOnes)
`endif
  );

  // ---------------- clock ----------------
  always #10 Clk50MHz = ~Clk50MHz;

  // ---------------- helpers ----------------
  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk50MHz);
  endtask

  // Decimal model of one step; queues the result the DUT must show with Tick.
  task automatic model_step();
    int  nv;
    logic w;
    w = 1'b0;
    if (Up) begin
      if (model_val == TERM) begin nv = 0; w = 1'b1; end
      else nv = model_val + 1;
    end else begin
      if (model_val == 0) begin nv = TERM; w = 1'b1; end
      else nv = model_val - 1;
    end
    model_val = nv;
    exp_q.push_back({w, to_bcd(nv)});
  endtask

  // One slow-clock pulse: 4 fast cycles high, 4 low. Tick must appear
  // exactly after the third rising edge following the rise.
  task automatic slow_pulse(input logic expect_step);
    @(negedge Clk50MHz);
    Clk5Hz = 1'b1;
    if (expect_step) model_step();
    @(posedge Clk50MHz);
    @(posedge Clk50MHz);
    #1 check("tick_early", Tick, 0);
    @(posedge Clk50MHz);
    #1 check("tick_latency", Tick, expect_step);
    @(posedge Clk50MHz);
    @(negedge Clk50MHz);
    Clk5Hz = 1'b0;
    cycles(4);
  endtask

  task automatic load_val(input logic [7:0] v);
    @(negedge Clk50MHz);
    Load    = 1'b1;
    LoadVal = v;
    @(negedge Clk50MHz);
    Load    = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge Clk50MHz) begin
    logic [8:0] e;
    if (Rst_n && Tick) begin
      tick_seen++;
      check("tick_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tick_result", {Wrap, Tens, Ones}, e);
      end
    end
    if (Wrap) check("wrap_with_tick", Tick, 1);
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset with slow clock already high
    Rst_n  = 1'b0;
    Clk5Hz = 1'b1;
    En     = 1'b1;
    Up     = 1'b1;
    cycles(3);
    check("rst_count",   {Tens, Ones}, 8'h00);
    check("rst_tick",    Tick, 0);
    check("rst_wrap",    Wrap, 0);
    check("rst_loaderr", LoadErr, 0);
`ifdef SEVEN_SEG_EN
    check("rst_segtens", SegTens, SEG_ZERO);
    check("rst_segones", SegOnes, SEG_ZERO);
`endif

    // 1: high level at release gives no step; a fresh rise gives one
    @(negedge Clk50MHz);
    Rst_n = 1'b1;
    cycles(8);
    check("t1_hold", {Tens, Ones}, 8'h00);
    Clk5Hz = 1'b0;
    cycles(4);
    model_val = 0;
    slow_pulse(1'b1);
    check("t1_count", {Tens, Ones}, 8'h01);

    // 2: twelve steps from 00
    @(negedge Clk50MHz);
    Clr = 1'b1;
    @(negedge Clk50MHz);
    Clr = 1'b0;
    model_val = 0;
    check("t2_clr", {Tens, Ones}, 8'h00);
    base = tick_seen;
    repeat (12) slow_pulse(1'b1);
    check("t2_count", {Tens, Ones}, 8'h12);
    check("t2_ticks", tick_seen - base, 12);

    // 3: wrap at terminal both directions, and borrow across tens
    load_val(8'h59);
    model_val = 59;
    check("t3_load59", {Tens, Ones}, 8'h59);
    check("t3_load59_err", LoadErr, 0);
    Up = 1'b1;
    slow_pulse(1'b1);
    check("t3_wrap_up", {Tens, Ones}, 8'h00);
    Up = 1'b0;
    slow_pulse(1'b1);
    check("t3_wrap_down", {Tens, Ones}, 8'h59);
    slow_pulse(1'b1);
    check("t3_down", {Tens, Ones}, 8'h58);
    load_val(8'h50);
    model_val = 50;
    slow_pulse(1'b1);
    check("t3_borrow", {Tens, Ones}, 8'h49);

    // 4: Clr in the cycle the edge is live wins, no Tick
    Up = 1'b1;
    @(negedge Clk50MHz);
    Clk5Hz = 1'b1;
    @(posedge Clk50MHz);
    @(posedge Clk50MHz);
    @(negedge Clk50MHz);
    Clr = 1'b1;
    @(negedge Clk50MHz);
    Clr = 1'b0;
    model_val = 0;
    check("t4_clr_tick", Tick, 0);
    check("t4_clr_count", {Tens, Ones}, 8'h00);
    cycles(2);
    Clk5Hz = 1'b0;
    cycles(4);

    // 4b: En=0 holds the count through three edges
    load_val(8'h23);
    model_val = 23;
    En = 1'b0;
    repeat (3) slow_pulse(1'b0);
    check("t4_hold", {Tens, Ones}, 8'h23);
    En = 1'b1;

    // 5: rejected loads
    load_val(8'h6A);
    check("t5_6a_err", LoadErr, 1);
    check("t5_6a_count", {Tens, Ones}, 8'h23);
    cycles(1);
    check("t5_err_pulse", LoadErr, 0);
    load_val(8'h60);
    check("t5_60_err", LoadErr, 1);
    check("t5_60_count", {Tens, Ones}, 8'h23);
    load_val(8'h37);
    model_val = 37;
    check("t5_37_count", {Tens, Ones}, 8'h37);
    check("t5_37_err", LoadErr, 0);
    slow_pulse(1'b1);
    check("t5_step", {Tens, Ones}, 8'h38);

`ifdef SEVEN_SEG_EN
    // 6: segments lag the digits by one cycle
    load_val(8'h37);
    cycles(2);
    load_val(8'h09);
    check("t6_seg_lag", SegOnes, SEG_SEVEN);
    cycles(1);
    check("t6_segtens", SegTens, SEG_ZERO);
    check("t6_segones", SegOnes, SEG_NINE);
`endif

    // 6b: reset mid-count discards the pending edge
    Up = 1'b1;
    @(negedge Clk50MHz);
    Clk5Hz = 1'b1;
    @(posedge Clk50MHz);
    @(negedge Clk50MHz);
    Rst_n = 1'b0;
    @(negedge Clk50MHz);
    check("t6_rst_count", {Tens, Ones}, 8'h00);
    check("t6_rst_tick", Tick, 0);
    check("t6_rst_wrap", Wrap, 0);
    check("t6_rst_loaderr", LoadErr, 0);
`ifdef SEVEN_SEG_EN
    check("t6_rst_segtens", SegTens, SEG_ZERO);
    check("t6_rst_segones", SegOnes, SEG_ZERO);
`endif
    Rst_n = 1'b1;
    cycles(8);
    check("t6_no_step", {Tens, Ones}, 8'h00);
    Clk5Hz = 1'b0;
    cycles(4);
    model_val = 0;
    slow_pulse(1'b1);
    check("t6_rearm", {Tens, Ones}, 8'h01);

    cycles(4);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
